// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and constants for the axis egress slice
//
// Purpose : buffer state encoding and default beat layout used by the
//           egress top (axis_egress) and its skid buffer (axis_skid_buf).
// Ports   : none (package).
package axis_pkg;

  localparam int AXIS_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } axis_buf_state_e;

  // Default-width beat; blocks with a different data width declare the
  // same layout locally from their own parameter.
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic                       last;
  } axis_beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry skid buffer with registered valid/ready
//
// Purpose : output register (OR) drives the master side, skid register (SR)
//           catches the one beat that can arrive in the cycle the consumer
//           stalls. Both handshake outputs come straight from flops.
// Ports   : clk, rst_n (async, active-low)
//           i_data/i_last/i_valid -> o_ready   upstream beat + handshake
//           o_data/o_last/o_valid <- i_ready   downstream beat + handshake
//           o_state                            current buffer occupancy
module axis_skid_buf
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output axis_buf_state_e       o_state
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  axis_buf_state_e r_state;
  axis_buf_state_e w_next_state;
  beat_t           r_or;
  beat_t           r_sr;
  beat_t           w_in;
  logic            r_valid;
  logic            r_ready;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_or_from_in;
  logic            w_or_from_sr;
  logic            w_sr_load;

  assign w_in       = {i_data, i_last};
  assign w_in_fire  = i_valid && r_ready;
  assign w_out_fire = r_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: if (w_in_fire) w_next_state = ONE;
      ONE: begin
        if (w_in_fire && !w_out_fire)      w_next_state = FULL;
        else if (!w_in_fire && w_out_fire) w_next_state = EMPTY;
      end
      FULL:    if (w_out_fire) w_next_state = ONE;
      default: w_next_state = EMPTY;
    endcase
  end

  always_comb begin
    w_or_from_in = 1'b0;
    w_or_from_sr = 1'b0;
    w_sr_load    = 1'b0;
    case (r_state)
      EMPTY: w_or_from_in = w_in_fire;
      ONE: begin
        // Pass-through when both sides fire; park in SR when only input fires.
        w_or_from_in = w_in_fire && w_out_fire;
        w_sr_load    = w_in_fire && !w_out_fire;
      end
      FULL:    w_or_from_sr = w_out_fire;
      default: ;
    endcase
  end

  // valid/ready are precomputed from the next state so neither output has a
  // combinational path from the opposite side's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or    <= '0;
      r_sr    <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_valid <= (w_next_state != EMPTY);
      r_ready <= (w_next_state != FULL);
      if (w_or_from_in)      r_or <= w_in;
      else if (w_or_from_sr) r_or <= r_sr;
      if (w_sr_load)         r_sr <= w_in;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_or.data;
  assign o_last  = r_or.last;
  assign o_state = r_state;

endmodule

// File: rtl/axis_egress.sv
// rtl/axis_egress.sv - AXI4-Stream egress with skid buffer and send status
//
// Purpose : forwards the internal stream to m_axis through axis_skid_buf and
//           keeps beat/frame counters plus an in-frame flag.
// Ports   : clk, rst_n (async, active-low)
//           axis_tdata/tvalid/tlast -> axis_tready        internal stream in
//           m_axis_tdata/tvalid/tlast <- m_axis_tready    external master out
//           beat_send, in_frame, frame_count, beat_count, idle   status
// Option  : AXIS_EGRESS_CHECK_EN enables simulation-only protocol checks.
module axis_egress
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  axis_tdata,
  input  logic                   axis_tvalid,
  output logic                   axis_tready,
  input  logic                   axis_tlast,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   beat_send,
  output logic                   in_frame,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic                   idle
);

  axis_buf_state_e        w_state;
  logic                   w_out_fire;
  logic                   r_in_frame;
  logic [COUNT_WIDTH-1:0] r_frame_count;
  logic [COUNT_WIDTH-1:0] r_beat_count;

  axis_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_data  (axis_tdata),
    .i_last  (axis_tlast),
    .i_valid (axis_tvalid),
    .o_ready (axis_tready),
    .o_data  (m_axis_tdata),
    .o_last  (m_axis_tlast),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready),
    .o_state (w_state)
  );

  assign w_out_fire = m_axis_tvalid && m_axis_tready;

  // Counters wrap naturally; in_frame tracks whether the last sent beat left
  // a frame open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_count  <= '0;
      r_frame_count <= '0;
      r_in_frame    <= 1'b0;
    end else if (w_out_fire) begin
      r_beat_count <= r_beat_count + COUNT_WIDTH'(1);
      if (m_axis_tlast) begin
        r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
        r_in_frame    <= 1'b0;
      end else begin
        r_in_frame    <= 1'b1;
      end
    end
  end

  assign beat_send   = w_out_fire;
  assign in_frame    = r_in_frame;
  assign frame_count = r_frame_count;
  assign beat_count  = r_beat_count;
  assign idle        = (w_state == EMPTY);

`ifdef AXIS_EGRESS_CHECK_EN
`ifndef SYNTHESIS
  logic w_in_fire;
  assign w_in_fire = axis_tvalid && axis_tready;

  a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_axis_tvalid && !m_axis_tready) |=> m_axis_tvalid)
    else $fatal(1, "m_axis_tvalid dropped without handshake");

  a_data_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_axis_tvalid && !m_axis_tready) |=> ($stable(m_axis_tdata) && $stable(m_axis_tlast)))
    else $fatal(1, "m_axis_tdata/tlast changed while stalled");

  a_no_full_in: assert property (@(posedge clk) disable iff (!rst_n)
    (w_state == FULL) |-> !w_in_fire)
    else $fatal(1, "beat accepted while buffer full");

  a_cnt_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !w_out_fire |=> ($stable(r_beat_count) && $stable(r_frame_count)))
    else $fatal(1, "counter changed without a sent beat");
`endif
`else
  // Protocol checks not compiled in this build.
`endif

endmodule

// File: tb/tb_axis_egress.sv
// tb/tb_axis_egress.sv - self-checking bench for axis_egress
module tb_axis_egress;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] axis_tdata = '0;
  logic        axis_tvalid = 1'b0;
  logic        axis_tlast = 1'b0;
  logic        m_axis_tready = 1'b0;

  logic        axis_tready, m_axis_tvalid, m_axis_tlast, beat_send, in_frame, idle;
  logic [63:0] m_axis_tdata;
  logic [31:0] frame_count, beat_count;

  logic        n_axis_tready, n_m_axis_tvalid, n_m_axis_tlast, n_beat_send, n_in_frame, n_idle;
  logic [63:0] n_m_axis_tdata;
  logic [3:0]  n_frame_count, n_beat_count;

  always #5 clk = ~clk;

  axis_egress #(.DATA_WIDTH(64), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .axis_tlast(axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .beat_send(beat_send), .in_frame(in_frame), .frame_count(frame_count),
    .beat_count(beat_count), .idle(idle)
  );

  axis_egress #(.DATA_WIDTH(64), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(n_axis_tready),
    .axis_tlast(axis_tlast),
    .m_axis_tdata(n_m_axis_tdata), .m_axis_tvalid(n_m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(n_m_axis_tlast),
    .beat_send(n_beat_send), .in_frame(n_in_frame), .frame_count(n_frame_count),
    .beat_count(n_beat_count), .idle(n_idle)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: accepted beats in order plus running totals.
  logic [64:0] exp_q[$];
  logic [64:0] out_q[$];
  int          in_cyc[$];
  int          out_cyc[$];
  int          exp_beats = 0;
  int          exp_frames = 0;
  logic        exp_in_frame = 1'b0;

  int          cyc = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = '0;
  logic        in_frame_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (axis_tvalid && axis_tready) in_cyc.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back({m_axis_tlast, m_axis_tdata});
        out_cyc.push_back(cyc);
      end
      if (prev_stall && (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== prev_beat))
        stall_viol <= stall_viol + 1;
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_beat  <= {m_axis_tlast, m_axis_tdata};
      if (in_frame) in_frame_seen <= 1'b1;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic clear_obs();
    exp_q.delete(); out_q.delete(); in_cyc.delete(); out_cyc.delete();
    in_frame_seen = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_beats = 0; exp_frames = 0; exp_in_frame = 1'b0;
    clear_obs();
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    axis_tdata  = d;
    axis_tlast  = l;
    axis_tvalid = 1'b1;
    @(negedge clk);
    while (!axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL send_timeout: axis_tready stayed %0b, required 1", axis_tready);
    end else begin
      exp_q.push_back({l, d});
      exp_beats++;
      if (l) exp_frames++;
      exp_in_frame = !l;
    end
    @(posedge clk);
    #1;
    axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    while (!idle && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL drain_timeout: idle=%0b, required 1", idle);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (beat_count !== 32'(exp_beats)) $display("FAIL %s beat_count: got %0d, required %0d", tag, beat_count, exp_beats);
    else passes++;
    checks++;
    if (frame_count !== 32'(exp_frames)) $display("FAIL %s frame_count: got %0d, required %0d", tag, frame_count, exp_frames);
    else passes++;
    checks++;
    if (n_beat_count !== 4'(exp_beats)) $display("FAIL %s beat_count_w4: got %0d, required %0d", tag, n_beat_count, exp_beats % 16);
    else passes++;
    checks++;
    if (n_frame_count !== 4'(exp_frames)) $display("FAIL %s frame_count_w4: got %0d, required %0d", tag, n_frame_count, exp_frames % 16);
    else passes++;
    checks++;
    if (in_frame !== exp_in_frame) $display("FAIL %s in_frame: got %0b, required %0b", tag, in_frame, exp_in_frame);
    else passes++;
  endtask

  task automatic check_order(input string tag);
    int bad;
    bad = 0;
    checks++;
    if (out_q.size() != exp_q.size()) $display("FAIL %s out_count: got %0d, required %0d", tag, out_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      if (out_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL %s order: %0d beats differ, required 0", tag, bad);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, axis_tready, in_frame} !== 4'b0000)
      $display("FAIL reset_flags: got v/l/rdy/inf=%b, required 0000", {m_axis_tvalid, m_axis_tlast, axis_tready, in_frame});
    else passes++;
    checks++;
    if (m_axis_tdata !== 64'h0) $display("FAIL reset_tdata: got %0h, required 0", m_axis_tdata);
    else passes++;
    checks++;
    if (beat_count !== 32'h0 || frame_count !== 32'h0) $display("FAIL reset_counts: got %0d/%0d, required 0/0", beat_count, frame_count);
    else passes++;
    checks++;
    if (idle !== 1'b1) $display("FAIL reset_idle: got %0b, required 1", idle);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (axis_tready !== 1'b1) $display("FAIL reset_release_ready: got %0b, required 1", axis_tready);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(64'(i), i == 7);
    drain();
    check_order("b2b");
    bad = 0;
    for (int i = 0; i < 8 && i < out_cyc.size() && i < in_cyc.size(); i++)
      if (out_cyc[i] != in_cyc[i] + 1 || (i > 0 && out_cyc[i] != out_cyc[i-1] + 1)) bad++;
    checks++;
    if (bad != 0 || out_cyc.size() != 8) $display("FAIL b2b_timing: %0d late/bubbled beats of %0d, required 0 of 8", bad, out_cyc.size());
    else passes++;
    check_counts("b2b");
  endtask

  task automatic test_stall();
    do_reset();
    m_axis_tready = 1'b0;
    send_beat(64'hA, 1'b0);
    send_beat(64'hB, 1'b1);
    @(negedge clk);
    checks++;
    if (axis_tready !== 1'b0 || idle !== 1'b0) $display("FAIL stall_full: got ready=%0b idle=%0b, required 0/0", axis_tready, idle);
    else passes++;
    checks++;
    if (m_axis_tdata !== 64'hA || m_axis_tvalid !== 1'b1) $display("FAIL stall_hold: got %0h v=%0b, required a v=1", m_axis_tdata, m_axis_tvalid);
    else passes++;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    checks++;
    if (idle !== 1'b1 || m_axis_tvalid !== 1'b0) $display("FAIL stall_drained: got idle=%0b v=%0b, required 1/0", idle, m_axis_tvalid);
    else passes++;
    check_order("stall");
    check_counts("stall");
  endtask

  task automatic test_random();
    int base_frames;
    do_reset();
    stall_viol = 0;
    base_frames = exp_frames;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
          send_beat({$urandom, $urandom}, (i % 10) == 9);
        end
      end
      begin
        int n;
        n = 0;
        while (out_q.size() < 1000 && n < 20000) begin
          @(posedge clk);
          #1;
          m_axis_tready = ($urandom_range(0, 1) == 1);
          n++;
        end
      end
    join
    drain();
    check_order("random");
    checks++;
    if (exp_frames - base_frames != 100 || frame_count !== 32'd100)
      $display("FAIL random_frames: got %0d, required 100", frame_count);
    else passes++;
    checks++;
    if (stall_viol != 0) $display("FAIL random_stall_stable: got %0d changes, required 0", stall_viol);
    else passes++;
    check_counts("random");
  endtask

  task automatic test_wrap();
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 17; i++) send_beat(64'(100 + i), 1'b1);
    drain();
    checks++;
    if (n_beat_count !== 4'd1 || n_frame_count !== 4'd1) $display("FAIL wrap_w4: got %0d/%0d, required 1/1", n_beat_count, n_frame_count);
    else passes++;
    checks++;
    if (in_frame_seen !== 1'b0) $display("FAIL wrap_in_frame: got %0b, required 0", in_frame_seen);
    else passes++;
    check_order("wrap");
    check_counts("wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_axis_tready = 1'b1;
    send_beat(64'h10, 1'b0);
    drain();
    m_axis_tready = 1'b0;
    send_beat(64'h11, 1'b0);
    send_beat(64'h12, 1'b0);
    @(negedge clk);
    checks++;
    if (axis_tready !== 1'b0 || in_frame !== 1'b1) $display("FAIL mid_pre: got ready=%0b in_frame=%0b, required 0/1", axis_tready, in_frame);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || beat_count !== 32'h0 || frame_count !== 32'h0 || in_frame !== 1'b0 || idle !== 1'b1)
      $display("FAIL mid_async: got v=%0b bc=%0d fc=%0d inf=%0b idle=%0b, required 0/0/0/0/1", m_axis_tvalid, beat_count, frame_count, in_frame, idle);
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_beats = 0; exp_frames = 0; exp_in_frame = 1'b0;
    clear_obs();
    m_axis_tready = 1'b1;
    send_beat(64'h55, 1'b0);
    send_beat(64'h66, 1'b1);
    drain();
    check_order("mid");
    check_counts("mid");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
